pipe_stage_buffer: RTL
======================

Name: pipe_stage_buffer

Overview:
Parametrised pipeline-stage register that replaces fixed per-stage latches such as the MEM/WB one. It uses a valid/ready handshake and a 2-entry skid buffer, so backpressure never forms a combinational ready path across stages. It carries a generic data/rd/ctrl payload, supports flush, and exports writeback-forwarding info. It is instantiated between any two CPU pipeline stages.

Parameters:
DATA_W, 32, width of each data field
NDATA, 2, number of data fields carried (e.g. read_data, reg_data)
RD_W, 5, destination register index width
CTRL_W, 2, control bit count (e.g. MemToReg, RegWrite)
REGWR_BIT, 1, index within ctrl of the RegWrite bit
CNT_W, 16, perf counter width (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  reset
flush  in  1  discard all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  buffer can accept this cycle (registered)
in_data  in  NDATA*DATA_W  packed data fields, field0 in LSBs
in_rd  in  RD_W  destination register
in_ctrl  in  CTRL_W  control bits
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_data  out  NDATA*DATA_W  head data
out_rd  out  RD_W  head rd
out_ctrl  out  CTRL_W  head ctrl
fwd_valid  out  1  head will write the register file
fwd_rd  out  RD_W  = out_rd
fwd_data  out  DATA_W  = data field 0 of head

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, both entry valids = 0 and all payload registers = 0. Outputs: out_valid=0, out_data/out_rd/out_ctrl=0, fwd_valid=0, in_ready=1.
- Storage: main entry (head) drives out_*; skid entry holds overflow.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- States, encoded by {skid_v, main_v}:
  - EMPTY: push → ONE.
  - ONE: push&!pop → FULL (data to skid); push&pop → ONE (data to main); pop&!push → EMPTY.
  - FULL: pop → ONE (skid moves to main, skid_v=0); no pop → FULL.
- in_ready = !skid_v, registered. It never depends combinationally on out_ready.
- push in FULL is impossible because in_ready=0. in_valid while in_ready=0 has no effect, and upstream must hold its payload.
- Latency: 1 cycle from push to out_valid. Throughput is 1 entry/cycle while out_ready=1.
- Order is strict FIFO; skid data never overtakes main.
- Payload registers load only on a write into that entry. Output payload is held stable while out_valid & !out_ready.
- flush: at the next edge both valids → 0 and in_ready → 1. Flush beats a simultaneous push, which is dropped. Payload registers need not clear.
- fwd_valid = out_valid & out_ctrl[REGWR_BIT] & (out_rd != 0). It is combinational from registered state only.
- Asserting reset mid-transfer aborts everything; the block returns to EMPTY with the reset values listed above.

Optional Feature:
Macro PIPE_STAGE_BUFFER_PERF_EN.
- Defined: adds outputs stall_cnt[CNT_W] and bubble_cnt[CNT_W], both reset to 0.
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid.
  - Both saturate at all-ones and are not cleared by flush.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then in_valid=1 every cycle with data0=1,2,3… and out_ready=1 → out_valid rises 1 cycle after the first push, out_data0 = 1,2,3… with no gaps, in_ready stays 1.
2. Push A=0xA, B=0xB with out_ready=0 → out shows 0xA held; the cycle after B, in_ready=0. Raise out_ready → 0xA then 0xB pop, and in_ready returns to 1 one cycle after the first pop.
3. FULL state, then flush=1 with in_valid=1, data0=0xC → next cycle out_valid=0, in_ready=1, and 0xC never appears.
4. Head ctrl[REGWR_BIT]=1: with rd=5, data0=0x1234 → fwd_valid=1, fwd_rd=5, fwd_data=0x1234. With rd=0 → fwd_valid=0. With RegWrite=0 → fwd_valid=0.
5. Assert rst_n low while FULL → out_valid=0 and outputs zero immediately (asynchronous). After release, in_ready=1 and the next push works.
6. With PIPE_STAGE_BUFFER_PERF_EN defined: 3 cycles empty then 4 cycles stalled → bubble_cnt=3 and stall_cnt=4. With CNT_W=2 and 5 stall cycles → stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buffer
// Purpose  : Valid/ready pipeline-stage register with a 2-entry skid buffer,
//            flush and writeback-forwarding outputs. Optional perf counters
//            are enabled by defining PIPE_STAGE_BUFFER_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buffer #(
    parameter int DATA_W    = 32,
    parameter int NDATA     = 2,
    parameter int RD_W      = 5,
    parameter int CTRL_W    = 2,
    parameter int REGWR_BIT = 1
`ifdef PIPE_STAGE_BUFFER_PERF_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NDATA*DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]         in_rd,
    input  logic [CTRL_W-1:0]       in_ctrl,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NDATA*DATA_W-1:0] out_data,
    output logic [RD_W-1:0]         out_rd,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic                    fwd_valid,
    output logic [RD_W-1:0]         fwd_rd,
    output logic [DATA_W-1:0]       fwd_data
`ifdef PIPE_STAGE_BUFFER_PERF_EN
    ,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
`endif
);

    localparam int c_DATA_ALL_W = NDATA * DATA_W;

    // State bits are {skid_v, main_v}
    localparam logic [1:0] c_EMPTY = 2'b00;
    localparam logic [1:0] c_ONE   = 2'b01;
    localparam logic [1:0] c_FULL  = 2'b11;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_load_main;
    logic                    w_main_from_skid;
    logic                    w_load_skid;

    logic [c_DATA_ALL_W-1:0] r_main_data;
    logic [RD_W-1:0]         r_main_rd;
    logic [CTRL_W-1:0]       r_main_ctrl;
    logic [c_DATA_ALL_W-1:0] r_skid_data;
    logic [RD_W-1:0]         r_skid_rd;
    logic [CTRL_W-1:0]       r_skid_ctrl;

    assign in_ready  = ~r_state[1];
    assign out_valid = r_state[0];
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = c_EMPTY;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_push) begin
                        w_load_main = 1'b1;
                        w_state_nxt = c_ONE;
                    end
                end
                c_ONE: begin
                    if (w_push && !w_pop) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = c_FULL;
                    end else if (w_push && w_pop) begin
                        w_load_main = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = c_EMPTY;
                    end
                end
                c_FULL: begin
                    if (w_pop) begin
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = c_ONE;
                    end
                end
                default: w_state_nxt = c_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload only moves on an actual write so the head stays stable under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_main_rd   <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_rd   <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main) begin
                r_main_data <= in_data;
                r_main_rd   <= in_rd;
                r_main_ctrl <= in_ctrl;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
                r_main_rd   <= r_skid_rd;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_rd   <= in_rd;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    assign out_data  = r_main_data;
    assign out_rd    = r_main_rd;
    assign out_ctrl  = r_main_ctrl;
    assign fwd_valid = r_state[0] & r_main_ctrl[REGWR_BIT] & (r_main_rd != '0);
    assign fwd_rd    = r_main_rd;
    assign fwd_data  = r_main_data[DATA_W-1:0];

`ifdef PIPE_STAGE_BUFFER_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating counters, deliberately untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (!out_valid && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire
